rld_app_arbiter: RTL and testbench
==================================

Name: rld_app_arbiter

Overview:
- Shares the RLDRAM-II controller's single application command/data port between two requesters (port 0, port 1).
- Round-robin grant; holds off all traffic until memory calibration completes.
- Tracks outstanding reads in a tag FIFO and steers in-order read data back to the issuing requester.
- Sits between user logic and the RLDRAM controller core, in the sysClk domain.

Parameters:
- APP_AD_WIDTH, 26, application address width: {3 control bits, 20 row/col address bits, 3 bank bits}.
- DATA_WIDTH, 144, application data width: one BL4 burst, 2 x 72-bit.
- TAG_DEPTH, 16, maximum outstanding reads; power of 2, minimum 2.

Ports:
- sysClk, in, 1, controller user clock.
- sysRst, in, 1, synchronous, active-high reset.
- cal_done, in, 1, controller calibration/init complete.
- rN_req, in, 1, request from port N (N = 0, 1); held until rN_ack.
- rN_wr, in, 1, 1 = write, 0 = read.
- rN_addr, in, APP_AD_WIDTH, request address.
- rN_wdata, in, DATA_WIDTH, write data; ignored for reads.
- rN_ack, out, 1, one-cycle pulse: request accepted by the controller.
- rN_rd_valid, out, 1, read data for port N is valid this cycle.
- rd_data, out, DATA_WIDTH, shared read-return data.
- app_cmd_valid, out, 1, command presented to the controller.
- app_cmd_ready, in, 1, controller can accept a command (its FIFOs are not full).
- app_cmd_wr, out, 1, command type.
- app_addr, out, APP_AD_WIDTH, command address.
- app_wdata, out, DATA_WIDTH, write data, transferred together with the command.
- app_rd_valid, in, 1, read data returned by the controller; in order, cannot be stalled.
- app_rd_data, in, DATA_WIDTH, returned read data.
- rd_err, out, 1, sticky: read data returned with no outstanding tag.
- tag_count, out, log2(TAG_DEPTH)+1, number of outstanding reads.

Behaviour:
- Reset:
  - State = WAIT_CAL; all outputs 0; tag FIFO flushed; tag_count = 0; rd_err = 0; round-robin pointer favours port 0.
  - Reset mid-transfer abandons the pending command; no ack is issued for it.
- FSM states: WAIT_CAL, IDLE, ISSUE.
  - WAIT_CAL -> IDLE when cal_done = 1.
  - IDLE -> ISSUE when an eligible request exists.
  - ISSUE -> ISSUE on handshake if another eligible request exists; otherwise ISSUE -> IDLE on handshake.
  - From IDLE, cal_done = 0 -> WAIT_CAL. In ISSUE, the current command completes first, then -> WAIT_CAL.
- Eligibility:
  - A request is eligible if rN_req = 1.
  - A read is eligible only if tag_count < TAG_DEPTH, counting a read issued in the same cycle.
- Arbitration:
  - When both ports are eligible, grant the port that was not granted most recently.
  - The pointer updates only on handshake.
- Grant latency: request sampled at edge n; app_cmd_valid, app_cmd_wr, app_addr, app_wdata are registered and valid from cycle n+1.
- Handshake: transfer occurs when app_cmd_valid & app_cmd_ready.
  - app_* outputs are held stable while app_cmd_valid = 1 and app_cmd_ready = 0.
  - rN_ack is high, combinationally, in the handshake cycle for the granted port only.
- Back-to-back:
  - At the handshake edge, the arbiter may load the next command. The just-acked port is excluded for that decision.
  - Alternating ports sustain 1 command/cycle; a single port sustains 1 command per 2 cycles.
- Read tags:
  - On a read handshake, push the port id into the tag FIFO.
  - On app_rd_valid, pop the head. Assert the matching rN_rd_valid for 1 cycle with rd_data = app_rd_data, registered: 1-cycle latency.
  - Push and pop in the same cycle leave tag_count unchanged.
- Empty pop: app_rd_valid with tag_count = 0 sets rd_err (sticky until reset); no rN_rd_valid is asserted; the data is dropped.
- Writes do not touch the tag FIFO.
- The FIFO pointers wrap modulo TAG_DEPTH.

Test Plan:
- Calibration gating: cal_done = 0, r0_req = 1 for 20 cycles -> app_cmd_valid stays 0. Raise cal_done -> app_cmd_valid = 1 two cycles later with r0_addr; r0_ack pulses on handshake.
- Round-robin: both ports issue continuous writes, app_cmd_ready = 1 -> grants alternate 0,1,0,1… at 1 command/cycle; each rN_ack pulses every 2nd cycle.
- Backpressure: app_cmd_ready = 0 for 5 cycles during a write with addr = 0x155AAAA -> app_addr and app_wdata stay stable, no ack; ack appears in the cycle ready rises.
- Tag limit: port 1 issues 16 reads with no returns -> tag_count = 16, 17th read not granted, port 0 write still granted. One app_rd_valid -> r1_rd_valid, tag_count = 15, 17th read then issues.
- Read steering: reads issued in port order 0,1,1,0, then 4 returns D0..D3 -> r0_rd_valid carries D0, r1 carries D1 and D2, r0 carries D3, each 1 cycle after app_rd_valid.
- Error and reset: app_rd_valid with tag_count = 0 -> rd_err = 1 and held. Assert sysRst mid-backpressure -> all outputs 0, tag_count = 0, rd_err = 0 next cycle.

Source files
------------

// File: rtl/rld_app_arbiter.sv
// rld_app_arbiter
//   Shares the RLDRAM-II controller application port between two requesters.
//   Round-robin grant, gated by memory calibration. Outstanding reads are
//   tracked in a small tag FIFO so in-order read data can be steered back to
//   the requester that issued each read.
//
// Ports
//   sysClk, sysRst            : user clock, synchronous active-high reset
//   cal_done                  : controller calibration complete
//   rN_req/wr/addr/wdata      : requester N command (held until rN_ack)
//   rN_ack                    : handshake pulse for the granted requester
//   rN_rd_valid, rd_data      : steered read return (1-cycle registered)
//   app_cmd_*/app_addr/wdata  : command towards the controller
//   app_rd_valid/app_rd_data  : in-order read return from the controller
//   rd_err                    : sticky, read data arrived with no tag
//   tag_count                 : outstanding reads
module rld_app_arbiter #(
  parameter int APP_AD_WIDTH = 26,
  parameter int DATA_WIDTH   = 144,
  parameter int TAG_DEPTH    = 16
) (
  input  logic                      sysClk,
  input  logic                      sysRst,
  input  logic                      cal_done,
  input  logic                      r0_req,
  input  logic                      r0_wr,
  input  logic [APP_AD_WIDTH-1:0]   r0_addr,
  input  logic [DATA_WIDTH-1:0]     r0_wdata,
  output logic                      r0_ack,
  output logic                      r0_rd_valid,
  input  logic                      r1_req,
  input  logic                      r1_wr,
  input  logic [APP_AD_WIDTH-1:0]   r1_addr,
  input  logic [DATA_WIDTH-1:0]     r1_wdata,
  output logic                      r1_ack,
  output logic                      r1_rd_valid,
  output logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      app_cmd_valid,
  input  logic                      app_cmd_ready,
  output logic                      app_cmd_wr,
  output logic [APP_AD_WIDTH-1:0]   app_addr,
  output logic [DATA_WIDTH-1:0]     app_wdata,
  input  logic                      app_rd_valid,
  input  logic [DATA_WIDTH-1:0]     app_rd_data,
  output logic                      rd_err,
  output logic [$clog2(TAG_DEPTH):0] tag_count
);

  localparam int PTR_W = $clog2(TAG_DEPTH);

  typedef enum logic [1:0] {WAIT_CAL, IDLE, ISSUE} state_t;

  state_t                   state_reg, state_next;
  logic                     cmd_wr_reg;
  logic [APP_AD_WIDTH-1:0]  cmd_addr_reg;
  logic [DATA_WIDTH-1:0]    cmd_wdata_reg;
  logic                     cmd_port_reg;
  logic                     last_port_reg;   // port granted most recently

  logic                     tag_mem [TAG_DEPTH];
  logic [PTR_W-1:0]         wr_ptr_reg, rd_ptr_reg;
  logic [PTR_W:0]           tag_count_reg;
  logic                     rd_err_reg;
  logic [1:0]               rd_valid_reg;
  logic [DATA_WIDTH-1:0]    rd_data_reg;

  logic [1:0]               req, wr, elig, cand, ack;
  logic [APP_AD_WIDTH-1:0]  addr_arr  [2];
  logic [DATA_WIDTH-1:0]    wdata_arr [2];
  logic                     handshake, push, pop, read_room, load, sel;
  logic [PTR_W+1:0]         count_eff;

  assign req          = {r1_req, r0_req};
  assign wr           = {r1_wr, r0_wr};
  assign addr_arr[0]  = r0_addr;
  assign addr_arr[1]  = r1_addr;
  assign wdata_arr[0] = r0_wdata;
  assign wdata_arr[1] = r1_wdata;

  assign handshake = (state_reg == ISSUE) & app_cmd_ready;
  assign push      = handshake & ~cmd_wr_reg;
  assign pop       = app_rd_valid & (tag_count_reg != '0);

  // A read being issued this cycle already owns a tag slot; returns landing
  // this cycle are not credited until the next cycle.
  assign count_eff = {1'b0, tag_count_reg} + {{(PTR_W+1){1'b0}}, push};
  assign read_room = count_eff < (PTR_W+2)'(TAG_DEPTH);

  for (genvar gi = 0; gi < 2; gi++) begin : g_port
    assign elig[gi] = req[gi] & (wr[gi] | read_room);
    assign ack[gi]  = handshake & (cmd_port_reg == 1'(gi));
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    cand       = elig;
    // The acked port still shows its old request this cycle; skip it.
    if (handshake) cand[cmd_port_reg] = 1'b0;
    sel = (&cand) ? ~last_port_reg : cand[1];
    case (state_reg)
      WAIT_CAL: if (cal_done) state_next = IDLE;
      IDLE: begin
        if (!cal_done) begin
          state_next = WAIT_CAL;
        end else if (|cand) begin
          load       = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (handshake) begin
          if (!cal_done)  state_next = WAIT_CAL;
          else if (|cand) load = 1'b1;
          else            state_next = IDLE;
        end
      end
      default: state_next = WAIT_CAL;
    endcase
  end

  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      state_reg     <= WAIT_CAL;
      cmd_wr_reg    <= 1'b0;
      cmd_addr_reg  <= '0;
      cmd_wdata_reg <= '0;
      cmd_port_reg  <= 1'b0;
      last_port_reg <= 1'b1;          // so port 0 wins the first tie
    end else begin
      state_reg <= state_next;
      if (load) begin
        cmd_wr_reg    <= wr[sel];
        cmd_addr_reg  <= addr_arr[sel];
        cmd_wdata_reg <= wdata_arr[sel];
        cmd_port_reg  <= sel;
      end
      if (handshake) last_port_reg <= cmd_port_reg;
    end
  end

  // Tag storage has no reset; only the pointers define its contents.
  always_ff @(posedge sysClk) begin
    if (push) tag_mem[wr_ptr_reg] <= cmd_port_reg;
  end

  always_ff @(posedge sysClk) begin
    if (sysRst) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      tag_count_reg <= '0;
      rd_err_reg    <= 1'b0;
      rd_valid_reg  <= 2'b00;
      rd_data_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   tag_count_reg <= tag_count_reg + (PTR_W+1)'(1);
        2'b01:   tag_count_reg <= tag_count_reg - (PTR_W+1)'(1);
        default: tag_count_reg <= tag_count_reg;
      endcase
      rd_valid_reg <= 2'b00;
      if (pop) begin
        rd_valid_reg <= 2'b01 << tag_mem[rd_ptr_reg];
        rd_data_reg  <= app_rd_data;
      end else if (app_rd_valid) begin
        rd_err_reg <= 1'b1;
      end
    end
  end

  assign app_cmd_valid = (state_reg == ISSUE);
  assign app_cmd_wr    = cmd_wr_reg;
  assign app_addr      = cmd_addr_reg;
  assign app_wdata     = cmd_wdata_reg;
  assign r0_ack        = ack[0];
  assign r1_ack        = ack[1];
  assign r0_rd_valid   = rd_valid_reg[0];
  assign r1_rd_valid   = rd_valid_reg[1];
  assign rd_data       = rd_data_reg;
  assign rd_err        = rd_err_reg;
  assign tag_count     = tag_count_reg;

endmodule

// File: tb/tb_rld_app_arbiter.sv
`timescale 1ns/1ps
module tb_rld_app_arbiter;
  localparam int AW = 26;
  localparam int DW = 144;
  localparam int TD = 16;

  logic sysClk = 1'b0;
  logic sysRst, cal_done;
  logic r0_req, r0_wr, r1_req, r1_wr;
  logic [AW-1:0] r0_addr, r1_addr;
  logic [DW-1:0] r0_wdata, r1_wdata;
  logic r0_ack, r1_ack, r0_rd_valid, r1_rd_valid;
  logic [DW-1:0] rd_data;
  logic app_cmd_valid, app_cmd_ready, app_cmd_wr;
  logic [AW-1:0] app_addr;
  logic [DW-1:0] app_wdata;
  logic app_rd_valid;
  logic [DW-1:0] app_rd_data;
  logic rd_err;
  logic [4:0] tag_count;

  always #5 sysClk = ~sysClk;

  rld_app_arbiter #(.APP_AD_WIDTH(AW), .DATA_WIDTH(DW), .TAG_DEPTH(TD)) dut (
    .sysClk(sysClk), .sysRst(sysRst), .cal_done(cal_done),
    .r0_req(r0_req), .r0_wr(r0_wr), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rd_valid(r0_rd_valid),
    .r1_req(r1_req), .r1_wr(r1_wr), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rd_valid(r1_rd_valid),
    .rd_data(rd_data),
    .app_cmd_valid(app_cmd_valid), .app_cmd_ready(app_cmd_ready),
    .app_cmd_wr(app_cmd_wr), .app_addr(app_addr), .app_wdata(app_wdata),
    .app_rd_valid(app_rd_valid), .app_rd_data(app_rd_data),
    .rd_err(rd_err), .tag_count(tag_count)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // One pending command slot, a list of outstanding read owners, and the
  // rule set: calibration gating, round robin, tag limit, in-order return.
  bit            m_valid, m_wr, m_port, m_last, m_cal, m_err;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_wdata, m_rd_data;
  bit [1:0]      m_rdv;
  int            tags[$];

  always @(posedge sysClk) begin : model
    bit hs, room;
    bit [1:0] e;
    int p;
    cyc++;
    if (sysRst) begin
      m_valid = 0; m_wr = 0; m_port = 0; m_last = 1; m_cal = 0; m_err = 0;
      m_addr = '0; m_wdata = '0; m_rd_data = '0; m_rdv = 0;
      tags.delete();
    end else begin
      hs   = m_valid && app_cmd_ready;
      room = (tags.size() + ((hs && !m_wr) ? 1 : 0)) < TD;
      e[0] = r0_req && (r0_wr || room);
      e[1] = r1_req && (r1_wr || room);
      if (hs) begin
        e[m_port] = 0;
        m_last = m_port;
      end
      m_rdv = 0;
      if (app_rd_valid) begin
        if (tags.size() == 0) m_err = 1;
        else begin
          p = tags.pop_front();
          m_rdv[p] = 1;
          m_rd_data = app_rd_data;
        end
      end
      if (hs && !m_wr) tags.push_back(int'(m_port));
      if (!m_cal) begin
        m_cal = cal_done;
      end else if (!m_valid || hs) begin
        if (!cal_done) begin
          m_cal = 0; m_valid = 0;
        end else if (e != 2'b00) begin
          p = (e == 2'b11) ? (m_last ? 0 : 1) : (e[1] ? 1 : 0);
          m_valid = 1;
          m_port  = p[0];
          m_wr    = p[0] ? r1_wr : r0_wr;
          m_addr  = p[0] ? r1_addr : r0_addr;
          m_wdata = p[0] ? r1_wdata : r0_wdata;
        end else begin
          m_valid = 0;
        end
      end
    end
  end

  // ---------------- per-cycle compare + logs ----------------
  int            grant_log[$];
  int            grant_cyc[$];
  int            rd_port_log[$];
  logic [DW-1:0] rd_data_log[$];

  always @(negedge sysClk) begin
    if (chk_en) begin
      chk("cmd_valid", DW'(app_cmd_valid), DW'(m_valid));
      if (m_valid) begin
        chk("cmd_wr", DW'(app_cmd_wr), DW'(m_wr));
        chk("app_addr", DW'(app_addr), DW'(m_addr));
        chk("app_wdata", app_wdata, m_wdata);
      end
      chk("r0_ack", DW'(r0_ack), DW'(m_valid && app_cmd_ready && !m_port));
      chk("r1_ack", DW'(r1_ack), DW'(m_valid && app_cmd_ready && m_port));
      chk("r0_rd_valid", DW'(r0_rd_valid), DW'(m_rdv[0]));
      chk("r1_rd_valid", DW'(r1_rd_valid), DW'(m_rdv[1]));
      if (m_rdv != 0) chk("rd_data", rd_data, m_rd_data);
      chk("rd_err", DW'(rd_err), DW'(m_err));
      chk("tag_count", DW'(tag_count), DW'(tags.size()));
      if (r0_ack || r1_ack) begin
        grant_log.push_back(r1_ack ? 1 : 0);
        grant_cyc.push_back(cyc);
        $display("cmd  port=%0d wr=%0d addr=%h tags=%0d", r1_ack ? 1 : 0, app_cmd_wr, app_addr, tag_count);
      end
      if (r0_rd_valid || r1_rd_valid) begin
        rd_port_log.push_back(r1_rd_valid ? 1 : 0);
        rd_data_log.push_back(rd_data);
        $display("read port=%0d data=%h", r1_rd_valid ? 1 : 0, rd_data);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge sysClk);
    #1;
  endtask

  task automatic drive(input int p, input bit req, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin
      r0_req = req; r0_wr = wr; r0_addr = a; r0_wdata = d;
    end else begin
      r1_req = req; r1_wr = wr; r1_addr = a; r1_wdata = d;
    end
  endtask

  // Issues n commands back to back from one port, each held until acked.
  task automatic request(input int p, input int n, input bit wr, input logic [AW-1:0] base);
    for (int i = 0; i < n; i++) begin
      bit got;
      int budget;
      logic [AW-1:0] a;
      a = base + AW'(i);
      drive(p, 1, wr, a, {a, 118'(i)});
      got = 0;
      budget = 0;
      while (!got && budget < 300) begin
        @(negedge sysClk);
        got = (p == 0) ? r0_ack : r1_ack;
        step();
        budget++;
      end
      chk($sformatf("ack_wait_p%0d", p), DW'(got), DW'(1));
    end
    drive(p, 0, 0, '0, '0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [DW-1:0] dvals [4];
  logic [DW-1:0] d_tag;

  initial begin
    bit seen0, seen1, got;
    dvals[0] = {9{16'hD0D0}};
    dvals[1] = {9{16'hD1D1}};
    dvals[2] = {9{16'hD2D2}};
    dvals[3] = {9{16'hD3D3}};
    d_tag    = {9{16'hABCD}};
    sysRst = 1; cal_done = 0; app_cmd_ready = 1; app_rd_valid = 0; app_rd_data = '0;
    drive(0, 0, 0, '0, '0);
    drive(1, 0, 0, '0, '0);
    step();
    chk_en = 1;
    @(negedge sysClk);
    chk("reset_valid", DW'(app_cmd_valid), DW'(0));
    chk("reset_tags", DW'(tag_count), DW'(0));
    chk("reset_err", DW'(rd_err), DW'(0));
    step();
    sysRst = 0;

    // Calibration gating
    drive(0, 1, 1, 26'h0000123, {9{16'h1234}});
    for (int i = 0; i < 20; i++) begin
      @(negedge sysClk);
      chk("cal_gate_valid", DW'(app_cmd_valid), DW'(0));
      step();
    end
    cal_done = 1;
    @(negedge sysClk);
    chk("cal_c0_valid", DW'(app_cmd_valid), DW'(0));
    step();
    @(negedge sysClk);
    chk("cal_c1_valid", DW'(app_cmd_valid), DW'(0));
    step();
    @(negedge sysClk);
    chk("cal_c2_valid", DW'(app_cmd_valid), DW'(1));
    chk("cal_c2_addr", DW'(app_addr), DW'(26'h0000123));
    chk("cal_c2_ack", DW'(r0_ack), DW'(1));
    step();
    drive(0, 0, 0, '0, '0);

    // Round robin with both ports streaming writes
    grant_log.delete();
    grant_cyc.delete();
    fork
      request(0, 6, 1, 26'h0000100);
      request(1, 6, 1, 26'h0000200);
    join
    chk("rr_count", DW'(grant_log.size()), DW'(12));
    if (grant_log.size() == 12) begin
      chk("rr_first", DW'(grant_log[0]), DW'(1));
      for (int i = 1; i < 12; i++) begin
        chk("rr_alternate", DW'(grant_log[i] != grant_log[i-1]), DW'(1));
        chk("rr_rate", DW'(grant_cyc[i] - grant_cyc[i-1]), DW'(1));
      end
    end

    // Backpressure
    app_cmd_ready = 0;
    drive(0, 1, 1, 26'h155AAAA, {9{16'h5A5A}});
    step();
    for (int i = 0; i < 5; i++) begin
      @(negedge sysClk);
      chk("bp_valid", DW'(app_cmd_valid), DW'(1));
      chk("bp_addr", DW'(app_addr), DW'(26'h155AAAA));
      chk("bp_wdata", app_wdata, {9{16'h5A5A}});
      chk("bp_no_ack", DW'(r0_ack), DW'(0));
      step();
    end
    app_cmd_ready = 1;
    @(negedge sysClk);
    chk("bp_ack", DW'(r0_ack), DW'(1));
    step();
    drive(0, 0, 0, '0, '0);

    // Tag limit
    request(1, 16, 0, 26'h0000300);
    @(negedge sysClk);
    chk("tag_full", DW'(tag_count), DW'(16));
    step();
    drive(1, 1, 0, 26'h00003FF, '0);
    drive(0, 1, 1, 26'h00000AB, {9{16'h00AB}});
    seen0 = 0; seen1 = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sysClk);
      if (r0_ack) seen0 = 1;
      if (r1_ack) seen1 = 1;
      step();
      if (seen0) drive(0, 0, 0, '0, '0);
    end
    chk("tag_write_granted", DW'(seen0), DW'(1));
    chk("tag_read_blocked", DW'(seen1), DW'(0));
    chk("tag_still_full", DW'(tag_count), DW'(16));
    app_rd_valid = 1; app_rd_data = d_tag;
    step();
    app_rd_valid = 0;
    @(negedge sysClk);
    chk("tag_ret_r1_valid", DW'(r1_rd_valid), DW'(1));
    chk("tag_ret_data", rd_data, d_tag);
    chk("tag_after_pop", DW'(tag_count), DW'(15));
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      if (i > 0) @(negedge sysClk);
      got = r1_ack;
      step();
    end
    chk("tag_17th_issued", DW'(got), DW'(1));
    drive(1, 0, 0, '0, '0);
    @(negedge sysClk);
    chk("tag_refull", DW'(tag_count), DW'(16));
    step();
    for (int i = 0; i < 16; i++) begin
      app_rd_valid = 1; app_rd_data = {9{16'(i)}};
      step();
    end
    app_rd_valid = 0;
    @(negedge sysClk);
    chk("tag_drained", DW'(tag_count), DW'(0));
    step();

    // Read steering 0,1,1,0
    request(0, 1, 0, 26'h0000400);
    request(1, 2, 0, 26'h0000410);
    request(0, 1, 0, 26'h0000420);
    rd_port_log.delete();
    rd_data_log.delete();
    for (int i = 0; i < 4; i++) begin
      app_rd_valid = 1; app_rd_data = dvals[i];
      step();
    end
    app_rd_valid = 0;
    step();
    step();
    chk("steer_count", DW'(rd_port_log.size()), DW'(4));
    if (rd_port_log.size() == 4) begin
      chk("steer_p0", DW'(rd_port_log[0]), DW'(0));
      chk("steer_p1", DW'(rd_port_log[1]), DW'(1));
      chk("steer_p2", DW'(rd_port_log[2]), DW'(1));
      chk("steer_p3", DW'(rd_port_log[3]), DW'(0));
      for (int i = 0; i < 4; i++) chk("steer_data", rd_data_log[i], dvals[i]);
    end

    // Empty-pop error, then reset during backpressure
    app_rd_valid = 1; app_rd_data = {9{16'hEEEE}};
    step();
    app_rd_valid = 0;
    @(negedge sysClk);
    chk("err_set", DW'(rd_err), DW'(1));
    chk("err_no_r0", DW'(r0_rd_valid), DW'(0));
    chk("err_no_r1", DW'(r1_rd_valid), DW'(0));
    repeat (3) step();
    @(negedge sysClk);
    chk("err_sticky", DW'(rd_err), DW'(1));
    step();
    app_cmd_ready = 0;
    drive(0, 1, 1, 26'h00000CC, {9{16'h00CC}});
    step();
    @(negedge sysClk);
    chk("rst_bp_valid", DW'(app_cmd_valid), DW'(1));
    step();
    sysRst = 1;
    step();
    sysRst = 0;
    @(negedge sysClk);
    chk("rst_valid", DW'(app_cmd_valid), DW'(0));
    chk("rst_ack", DW'(r0_ack), DW'(0));
    chk("rst_addr", DW'(app_addr), DW'(0));
    chk("rst_tags", DW'(tag_count), DW'(0));
    chk("rst_err", DW'(rd_err), DW'(0));
    step();
    app_cmd_ready = 1;
    got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge sysClk);
      got = r0_ack;
      step();
    end
    chk("rst_reissue", DW'(got), DW'(1));
    drive(0, 0, 0, '0, '0);
    step();
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
